// File: rtl/alu_seq_if.sv
// Request/response bundle between the ALU control stage and the sequential execute ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output start, ctrl, a, b, shamt,
        input  result, hi, zero, done, busy, err
    );

    modport slave (
        input  start, ctrl, a, b, shamt,
        output result, hi, zero, done, busy, err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: registered single-cycle ops plus an optional iterative
// shift-add multiplier / restoring divider, enabled by defining ALU_SEQ_MULDIV_EN.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpAddi = 4'b1000;
    localparam logic [3:0] OpSw   = 4'b1100;
    localparam logic [3:0] OpLw   = 4'b1101;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpBeq  = 4'b1110;
    localparam logic [3:0] OpOr   = 4'b0100;
    localparam logic [3:0] OpOri  = 4'b1011;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpAndi = 4'b1010;
    localparam logic [3:0] OpSlt  = 4'b0110;
    localparam logic [3:0] OpSlti = 4'b1001;
    localparam logic [3:0] OpSll  = 4'b0111;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0]  OpMult = 4'b0010;
    localparam logic [3:0]  OpDiv  = 4'b0011;
    localparam int unsigned CntW   = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;
`else
    typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic             req_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [4:0]       shamt_q;
    logic [WIDTH-1:0] result_q, hi_q;
    logic             zero_q, err_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             busy, done, accept, req_iter;

`ifdef ALU_SEQ_MULDIV_EN
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   acc_q, lo_q, opnd_q;
    logic               is_div_q, sa_q, sb_q;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [WIDTH-1:0]   acc_step, lo_step, fin_lo, fin_hi, abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic               last, div_zero;

    assign div_zero = (ctrl_q == OpDiv) && (b_q == '0);
    assign req_iter = (ctrl_q == OpMult) || ((ctrl_q == OpDiv) && !div_zero);
    assign last     = (cnt_q == CntW'(WIDTH - 1));
    assign abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
    assign abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
`else
    assign req_iter = 1'b0;
`endif

    // The capture cycle of an iterative op must not admit a second request.
    assign accept = bus.start && !busy && !(req_q && req_iter);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ctrl_q)
            OpAdd, OpAddi, OpSw, OpLw: alu_res = a_q + b_q;
            OpSub, OpBeq:              alu_res = a_q - b_q;
            OpOr, OpOri:               alu_res = a_q | b_q;
            OpAnd, OpAndi:             alu_res = a_q & b_q;
            OpSlt, OpSlti:             alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OpSll:                     alu_res = b_q << shamt_q;
            default:                   alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // acc holds the running high word / remainder; lo holds multiplier / dividend bits.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = div_trial[WIDTH] ? {acc_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                        : div_trial[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod = {acc_step, lo_step};
        if (is_div_q) begin
            fin_lo = (sa_q ^ sb_q) ? -lo_step : lo_step;
            fin_hi = sa_q ? -acc_step : acc_step;
        end else begin
            if (sa_q ^ sb_q) begin
                prod = -prod;
            end
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (req_q) begin
`ifdef ALU_SEQ_MULDIV_EN
                    state_d = req_iter ? StIter : StDone;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            StIter: begin
                if (last) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
`ifdef ALU_SEQ_MULDIV_EN
        busy = (state_q == StIter);
`else
        busy = 1'b0;
`endif
        done       = (state_q == StDone);
        bus.busy   = busy;
        bus.done   = done;
        bus.result = result_q;
        bus.hi     = hi_q;
        bus.zero   = zero_q;
        bus.err    = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
`endif
        end else begin
            req_q <= accept;
            if (accept) begin
                ctrl_q  <= bus.ctrl;
                a_q     <= bus.a;
                b_q     <= bus.b;
                shamt_q <= bus.shamt;
            end
            if (req_q && !busy) begin
`ifdef ALU_SEQ_MULDIV_EN
                if (div_zero) begin
                    result_q <= '1;
                    hi_q     <= a_q;
                    zero_q   <= 1'b0;
                    err_q    <= 1'b1;
                end else if (req_iter) begin
                    acc_q    <= '0;
                    lo_q     <= abs_a;
                    opnd_q   <= abs_b;
                    is_div_q <= (ctrl_q == OpDiv);
                    sa_q     <= a_q[WIDTH-1];
                    sb_q     <= b_q[WIDTH-1];
                    cnt_q    <= '0;
                end else
`endif
                begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    err_q    <= alu_err;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            if (busy) begin
                acc_q <= acc_step;
                lo_q  <= lo_step;
                cnt_q <= cnt_q + CntW'(1);
                if (last) begin
                    result_q <= fin_lo;
                    hi_q     <= fin_hi;
                    zero_q   <= (fin_lo == '0);
                    err_q    <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential execute-stage ALU that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code together with the operands from the register file or immediate path. It produces a registered result, a zero flag for branch resolution, and a HI word for multiply and divide. Single-cycle operations complete in one clock; MULT and DIV run as iterative shift-add and restoring-division engines under a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled on a rising edge only while busy=0.
- ctrl  in  4  ALU control code from the control decoder.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt, or an immediate already extended upstream.
- shamt  in  5  shift amount for SLL.
- result  out  WIDTH  main result (LO for MULT, quotient for DIV).
- hi  out  WIDTH  MULT upper word / DIV remainder; holds its value for all other ops.
- zero  out  1  result==0 for the completed op.
- done  out  1  one-cycle pulse; result, hi and flags are valid in this cycle.
- busy  out  1  high while an iterative op runs.
- err  out  1  illegal or disabled code, or divide by zero; updated with every done.

## Operation
- Code map:
  - 0000 ADD, 1000 ADDI, 1100 SW, 1101 LW: a+b, mod 2^WIDTH, no overflow trap.
  - 0001 SUB, 1110 BEQ: a-b.
  - 0100 OR, 1011 ORI: a|b.
  - 0101 AND, 1010 ANDI: a&b.
  - 0110 SLT, 1001 SLTI: signed a<b gives 1, otherwise 0.
  - 0111 SLL/NOP: b<<shamt.
  - 0010 MULT: signed product; low word to result, high word to hi.
  - 0011 DIV: signed; quotient truncates toward zero; remainder takes the sign of a.
  - 1111: illegal; result=0, err=1.
- States:
  - IDLE: start with a single-cycle op registers the outputs and pulses done next cycle. Start with MULT/DIV loads magnitudes and records operand signs → ITER.
  - ITER: counter runs 0..WIDTH-1, one partial step per cycle. Sign correction is applied at the last step → DONE.
  - DONE: done=1, busy=0 → IDLE. A new start is accepted in this cycle.
- DIV with b=0 skips ITER: result=all ones, hi=a, err=1, done on the next cycle.
- DIV of -2^(WIDTH-1) by -1: result=0x80000000, hi=0, err=0.
- start while busy=1 is ignored; no queuing.
- ctrl, a, b and shamt are captured at the accepting edge; later changes have no effect on an op in flight.

## Timing
- Reset: the state machine goes to IDLE and the counter clears. result=0, hi=0, zero=1, done=0, busy=0, err=0.
- Reset asserted mid-ITER aborts the op; no done is produced.
- Single-cycle op: start accepted at edge k; done=1 after edge k+1. Back-to-back starts give one result per cycle.
- MULT/DIV: start accepted at edge k; busy=1 from edge k+1 through edge k+WIDTH. done=1 after edge k+WIDTH+1.
- done is never high for two consecutive cycles from the same op.
- busy and done are never high together.

## Configuration
- ALU_SEQ_MULDIV_EN defined: MULT/DIV iterative engine present, with behaviour as above.
- ALU_SEQ_MULDIV_EN undefined:
  - The engine and ITER state are removed.
  - Codes 0010 and 0011 behave as illegal: single-cycle done, result=0, hi unchanged, err=1.
  - busy is tied to 0.

## Test plan
- Reset asserted then released with start=0 → result=0, hi=0, zero=1, done=0, busy=0, err=0.
- ctrl=0001, a=5, b=5, start pulse → done after 1 cycle, result=0, zero=1. ctrl=0110, a=0xFFFFFFFF, b=1 → result=1.
- ctrl=0010, a=-3, b=7 → busy for 32 cycles, done at cycle 33, result=0xFFFFFFEB, hi=0xFFFFFFFF, err=0.
- ctrl=0011, a=-7, b=2 → result=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with b=0 → done after 1 cycle, result=0xFFFFFFFF, hi=0xFFFFFFF9, err=1.
- Start a MULT, pulse start with ctrl=0000 at cycle 10, then assert rst_n=0 at cycle 20 → ADD ignored, no done, all outputs return to reset values.
- ctrl=1111 → result=0, err=1. Build without ALU_SEQ_MULDIV_EN, ctrl=0010 → done after 1 cycle, err=1, busy stays 0.
